// File: rtl/axi_rd_burst_master.sv
// AXI4 read master: splits a {address, bytes} request into INCR bursts that never cross
// a 4KB page, streams the R data downstream and reports one accumulated response per request.
module axi_rd_burst_master #(
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_valid,
    output logic              ctrl_ready,
    input  logic [47:0]       ctrl,
    output logic              status_valid,
    output logic [1:0]        status,
    output logic [31:0]       m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic [3:0]        m_arcache,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] addr;
    logic [16:0] remaining;
    logic [8:0]  burst_len;
    logic [8:0]  burst_cnt;
    logic [1:0]  resp_acc;

    logic [31:0] req_addr;
    logic [15:0] req_bytes;
    logic [16:0] req_beats;
    logic        accept;
    logic [12:0] bytes_to_4k;
    logic [12:0] beats_to_4k;
    logic [16:0] blen;
    logic [8:0]  burst_beats;
    logic [8:0]  burst_beats_m1;
    logic        beat;
    logic        last_beat;
    logic [1:0]  norm_resp;
    logic [1:0]  beat_resp;
    logic [1:0]  merged_resp;
    logic        err_now;

    assign req_addr  = ctrl[47:16];
    assign req_bytes = ctrl[15:0];
    assign req_beats = ({1'b0, req_bytes} + 17'(BYTES - 1)) >> SIZE;
    assign accept    = ctrl_valid && ctrl_ready;

    // Burst length is the smallest of what is left, the burst cap and the room in this 4KB page.
    assign bytes_to_4k = 13'h1000 - {1'b0, addr[11:0]};
    assign beats_to_4k = bytes_to_4k >> SIZE;

    always_comb begin
        blen = remaining;
        if (blen > 17'(MAX_BURST)) begin
            blen = 17'(MAX_BURST);
        end
        if (blen > {4'b0000, beats_to_4k}) begin
            blen = {4'b0000, beats_to_4k};
        end
    end

    assign burst_beats    = blen[8:0];
    assign burst_beats_m1 = burst_beats - 9'd1;

    assign beat      = (state == R) && m_rvalid && out_ready;
    assign last_beat = (burst_cnt == 9'd1);

    // A misplaced rlast is treated as a slave error but never shortens or extends the burst.
    always_comb begin
        norm_resp = (m_rresp == RESP_EXOKAY) ? RESP_OKAY : m_rresp;
        beat_resp = norm_resp;
        if ((m_rlast != last_beat) && (norm_resp == RESP_OKAY)) begin
            beat_resp = RESP_SLVERR;
        end
        merged_resp = (beat_resp > resp_acc) ? beat_resp : resp_acc;
    end

    assign err_now = (merged_resp != RESP_OKAY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        ctrl_ready   = 1'b0;
        status_valid = 1'b0;
        m_arvalid    = 1'b0;
        m_rready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        m_arlen      = 8'd0;
        case (state)
            IDLE: begin
                ctrl_ready = !rst;
                if (accept) begin
                    state_next = (req_beats == 17'd0) ? DONE : AR;
                end
            end
            AR: begin
                m_arvalid = 1'b1;
                m_arlen   = burst_beats_m1[7:0];
                if (m_arready) begin
                    state_next = R;
                end
            end
            R: begin
                out_valid = m_rvalid;
                m_rready  = out_ready;
                out_last  = last_beat && ((remaining == 17'd1) || err_now);
                if (beat && last_beat) begin
                    state_next = ((remaining == 17'd1) || err_now) ? DONE : AR;
                end
            end
            DONE: begin
                status_valid = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= 32'd0;
            remaining <= 17'd0;
            burst_len <= 9'd0;
            burst_cnt <= 9'd0;
            resp_acc  <= RESP_OKAY;
        end else begin
            if (accept) begin
                addr      <= req_addr & ~32'(BYTES - 1);
                remaining <= req_beats;
                resp_acc  <= RESP_OKAY;
            end
            if ((state == AR) && m_arready) begin
                burst_len <= burst_beats;
                burst_cnt <= burst_beats;
            end
            if (beat) begin
                burst_cnt <= burst_cnt - 9'd1;
                remaining <= remaining - 17'd1;
                resp_acc  <= merged_resp;
                if (last_beat) begin
                    addr <= addr + ({23'd0, burst_len} << SIZE);
                end
            end
        end
    end

    assign status    = resp_acc;
    assign m_araddr  = addr;
    assign m_arsize  = 3'(SIZE);
    assign m_arburst = 2'b01;
    assign m_arcache = 4'b0011;
    assign m_arprot  = 3'b000;
    assign out_data  = m_rdata;

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Bench for axi_rd_burst_master: behavioural AXI slave plus scoreboard queues of expected
// AR bursts, output beats and completion statuses.
module tb_axi_rd_burst_master;

    localparam int DATA_W    = 64;
    localparam int MAX_BURST = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              ctrl_valid;
    logic              ctrl_ready;
    logic [47:0]       ctrl;
    logic              status_valid;
    logic [1:0]        status;
    logic [31:0]       m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic [3:0]        m_arcache;
    logic [2:0]        m_arprot;
    logic              m_arvalid;
    logic              m_arready;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              m_rvalid;
    logic              m_rready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    axi_rd_burst_master #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl(ctrl),
        .status_valid(status_valid), .status(status),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    ar_t        exp_ar[$];
    beat_t      exp_beat[$];
    logic [1:0] exp_status[$];

    int checks = 0;
    int fails  = 0;
    int cyc = 0;
    int out_beats = 0;
    int accept_cyc = 0;
    int status_cyc = 0;
    int burst_no = 0;

    int         inj_burst = -1;
    int         inj_beat_a = -1;
    int         inj_beat_b = -1;
    logic [1:0] inj_resp_a = 2'b00;
    logic [1:0] inj_resp_b = 2'b00;
    int         bad_rlast_burst = -1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] mergeResp(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] na;
        logic [1:0] nb;
        na = (a == 2'b01) ? 2'b00 : a;
        nb = (b == 2'b01) ? 2'b00 : b;
        return (na > nb) ? na : nb;
    endfunction

    task automatic setInject(input int burst, input int beat_a, input logic [1:0] resp_a,
                             input int beat_b, input logic [1:0] resp_b, input int bad_rlast);
        inj_burst = burst;
        inj_beat_a = beat_a;
        inj_resp_a = resp_a;
        inj_beat_b = beat_b;
        inj_resp_b = resp_b;
        bad_rlast_burst = bad_rlast;
    endtask

    // Reference model of the burst split, data stream and response accumulation.
    task automatic pushExpected(input logic [31:0] addr, input int bytes);
        logic [31:0] a;
        logic [31:0] ba;
        logic [1:0]  st;
        logic [1:0]  r;
        int rem, b, blen, to4k;
        ar_t   e;
        beat_t d;
        a = addr & 32'hFFFF_FFF8;
        rem = (bytes + 7) / 8;
        st = 2'b00;
        b = 0;
        while (rem > 0 && st == 2'b00) begin
            to4k = (4096 - int'(a[11:0])) / 8;
            blen = rem;
            if (blen > MAX_BURST) blen = MAX_BURST;
            if (blen > to4k) blen = to4k;
            e.addr = a;
            e.len = 8'(blen - 1);
            exp_ar.push_back(e);
            for (int i = 0; i < blen; i++) begin
                r = 2'b00;
                if (b == inj_burst) begin
                    if (i == inj_beat_a) r = inj_resp_a;
                    if (i == inj_beat_b) r = inj_resp_b;
                end
                if (b == bad_rlast_burst && i == blen - 1) r = mergeResp(r, 2'b10);
                st = mergeResp(st, r);
                rem--;
                ba = a + 32'(8 * i);
                d.data = {~ba, ba};
                d.last = (i == blen - 1) && (rem == 0 || st != 2'b00);
                exp_beat.push_back(d);
            end
            a = a + 32'(blen * 8);
            b++;
        end
        exp_status.push_back(st);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input int bytes);
        pushExpected(addr, bytes);
        burst_no = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ctrl_ready) break;
        end
        checkOutput("ctrl_ready_idle", 64'(ctrl_ready), 64'd1);
        @(posedge clk);
        #1;
        ctrl = {addr, 16'(bytes)};
        ctrl_valid = 1'b1;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        ctrl_valid = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_ar.size() == 0 && exp_beat.size() == 0 && exp_status.size() == 0) break;
        end
        checkOutput({tag, "_drained"}, 64'(exp_ar.size() + exp_beat.size() + exp_status.size()), 64'd0);
    endtask

    task automatic waitBeats(input int count);
        int base;
        base = out_beats;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (out_beats >= base + count) break;
        end
        checkOutput("beats_progress", 64'(out_beats >= base + count), 64'd1);
    endtask

    // Slave and downstream monitor: sample on the falling edge, drive just after the rising edge.
    initial begin
        logic [31:0] cur_addr;
        logic [31:0] ar_addr;
        logic [7:0]  ar_len;
        logic [1:0]  r;
        logic        prev_sv;
        int beats_left, beat_idx, burst_cur;
        bit ar_fire, r_fire;
        ar_t   e;
        beat_t d;
        beats_left = 0;
        beat_idx = 0;
        burst_cur = 0;
        cur_addr = 32'd0;
        prev_sv = 1'b0;
        forever begin
            @(negedge clk);
            ar_fire = 1'b0;
            r_fire = 1'b0;
            if (!rst) begin
                if (m_arvalid && m_arready) begin
                    ar_fire = 1'b1;
                    ar_addr = m_araddr;
                    ar_len = m_arlen;
                    if (exp_ar.size() == 0) begin
                        checkOutput("ar_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_ar.pop_front();
                        checkOutput("araddr", 64'(m_araddr), 64'(e.addr));
                        checkOutput("arlen", 64'(m_arlen), 64'(e.len));
                        checkOutput("arsize", 64'(m_arsize), 64'd3);
                        checkOutput("arburst", 64'(m_arburst), 64'd1);
                        checkOutput("arcache", 64'(m_arcache), 64'd3);
                        checkOutput("arprot", 64'(m_arprot), 64'd0);
                    end
                end
                if (m_rvalid && m_rready) r_fire = 1'b1;
                if (out_valid && out_ready) begin
                    out_beats++;
                    if (exp_beat.size() == 0) begin
                        checkOutput("beat_unexpected", 64'd1, 64'd0);
                    end else begin
                        d = exp_beat.pop_front();
                        checkOutput("out_data", out_data, d.data);
                        checkOutput("out_last", 64'(out_last), 64'(d.last));
                    end
                end
                if (status_valid) begin
                    status_cyc = cyc;
                    checkOutput("status_pulse_width", 64'(prev_sv), 64'd0);
                    if (exp_status.size() == 0) begin
                        checkOutput("status_unexpected", 64'd1, 64'd0);
                    end else begin
                        checkOutput("status", 64'(status), 64'(exp_status.pop_front()));
                    end
                end
                prev_sv = status_valid;
            end else begin
                prev_sv = 1'b0;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                beats_left = 0;
                m_rvalid = 1'b0;
                m_rlast = 1'b0;
                m_rresp = 2'b00;
                m_arready = 1'b0;
            end else begin
                if (ar_fire) begin
                    cur_addr = ar_addr;
                    beats_left = int'(ar_len) + 1;
                    beat_idx = 0;
                    burst_cur = burst_no;
                    burst_no++;
                end
                if (r_fire) begin
                    beats_left--;
                    beat_idx++;
                    cur_addr = cur_addr + 32'd8;
                end
                if (m_rvalid && !r_fire) begin
                    m_rvalid = 1'b1;
                end else if (beats_left > 0 && $urandom_range(0, 3) != 0) begin
                    r = 2'b00;
                    if (burst_cur == inj_burst) begin
                        if (beat_idx == inj_beat_a) r = inj_resp_a;
                        if (beat_idx == inj_beat_b) r = inj_resp_b;
                    end
                    m_rvalid = 1'b1;
                    m_rdata = {~cur_addr, cur_addr};
                    m_rresp = r;
                    m_rlast = (beats_left == 1) && (burst_cur != bad_rlast_burst);
                end else begin
                    m_rvalid = 1'b0;
                    m_rlast = 1'b0;
                    m_rresp = 2'b00;
                end
                m_arready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        ctrl_valid = 1'b0;
        ctrl = 48'd0;
        out_ready = 1'b1;
        m_arready = 1'b0;
        m_rvalid = 1'b0;
        m_rdata = '0;
        m_rresp = 2'b00;
        m_rlast = 1'b0;
        #1;
        checkOutput("rst_ctrl_ready", 64'(ctrl_ready), 64'd0);
        checkOutput("rst_status_valid", 64'(status_valid), 64'd0);
        checkOutput("rst_status", 64'(status), 64'd0);
        checkOutput("rst_arvalid", 64'(m_arvalid), 64'd0);
        checkOutput("rst_araddr", 64'(m_araddr), 64'd0);
        checkOutput("rst_arlen", 64'(m_arlen), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(32'h0000_1000, 64);
        waitDone("single_burst");
        applyStimulus(32'h0000_0000, 512);
        waitDone("four_bursts");
        applyStimulus(32'h0000_0FF0, 64);
        waitDone("cross_4k");
        applyStimulus(32'h0000_2000, 12);
        waitDone("round_up");
        applyStimulus(32'h0000_2000, 0);
        waitDone("zero_bytes");
        checkOutput("zero_bytes_latency", 64'((status_cyc - accept_cyc) <= 2), 64'd1);
        applyStimulus(32'h0000_1004, 20);
        waitDone("unaligned");
        applyStimulus(32'hFFFF_FF80, 256);
        waitDone("addr_wrap");

        setInject(0, 2, 2'b10, -1, 2'b00, -1);
        applyStimulus(32'h0000_3000, 256);
        waitDone("slverr");
        setInject(0, 2, 2'b10, 5, 2'b11, -1);
        applyStimulus(32'h0000_3000, 256);
        waitDone("decerr");
        setInject(0, 4, 2'b01, -1, 2'b00, -1);
        applyStimulus(32'h0000_3000, 256);
        waitDone("exokay");
        setInject(-1, -1, 2'b00, -1, 2'b00, 0);
        applyStimulus(32'h0000_3000, 256);
        waitDone("bad_rlast");
        setInject(-1, -1, 2'b00, -1, 2'b00, -1);

        applyStimulus(32'h0000_4000, 256);
        waitBeats(3);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("m_rready_stall", 64'(m_rready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDone("backpressure");

        applyStimulus(32'h0000_5000, 256);
        waitBeats(4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_arvalid", 64'(m_arvalid), 64'd0);
        checkOutput("midrst_rready", 64'(m_rready), 64'd0);
        checkOutput("midrst_status_valid", 64'(status_valid), 64'd0);
        checkOutput("midrst_ctrl_ready", 64'(ctrl_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        exp_ar.delete();
        exp_beat.delete();
        exp_status.delete();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ctrl_ready", 64'(ctrl_ready), 64'd1);
        checkOutput("post_rst_arvalid", 64'(m_arvalid), 64'd0);

        applyStimulus(32'h0000_6000, 32);
        waitDone("recovery");
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
